// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - instruction cache types, states and defaults
package icache_pkg;

    import cpu_types_pkg::*;

    localparam int ICACHE_SETS = 16;

    // Tag field sized for the smallest legal cache (2 sets -> 29 tag bits).
    // Larger caches zero-extend their shorter tags into this field.
    localparam int ICACHE_TAG_MAX_W = 29;

    typedef struct packed {
        logic                        valid;
        logic [ICACHE_TAG_MAX_W-1:0] tag;
        word_t                       data;
    } icache_frame_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// rtl/icache_frames.sv - frame storage for the direct-mapped instruction cache
//
// Holds SETS one-word frames. Valid bits clear asynchronously on RST; tag and
// data arrays carry no reset so they can map onto plain storage.
//
// Ports:
//   CLK, RST   clock, asynchronous active-high reset
//   rd_idx     combinational read index
//   rd_frame   frame at rd_idx {valid, tag, data}
//   wr_en      write strobe, sampled on the rising edge
//   wr_idx     write index
//   wr_frame   frame written at wr_idx
module icache_frames
    import cpu_types_pkg::*;
    import icache_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [IDX_W-1:0] rd_idx,
    output icache_frame_t rd_frame,
    input  logic          wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  icache_frame_t wr_frame
);

    logic [SETS-1:0]             valid_q;
    logic [ICACHE_TAG_MAX_W-1:0] tag_q  [SETS];
    word_t                       data_q [SETS];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= wr_frame.valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_frame.tag;
            data_q[wr_idx] <= wr_frame.data;
        end
    end

    always_comb begin
        rd_frame       = '0;
        rd_frame.valid = valid_q[rd_idx];
        rd_frame.tag   = tag_q[rd_idx];
        rd_frame.data  = data_q[rd_idx];
    end

endmodule

// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped read-only instruction cache
//
// Serves fetch requests with a zero-latency hit path and fills misses one
// word at a time from the memory controller. Counts hits and misses.
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   imemREN, imemaddr     fetch request and byte address (bits [1:0] ignored)
//   ihit, imemload        hit strobe and instruction (0 when no hit)
//   iREN, iaddr           miss read request and word-aligned address
//   iwait, iload          controller busy flag and read data
//   hit_count, miss_count performance counters, wrap modulo 2^32
module icache
    import cpu_types_pkg::*;
    import icache_pkg::*;
#(
    parameter int SETS  = ICACHE_SETS,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    icache_state_t state_q, state_d;
    logic [29:0]   miss_word_q;
    word_t         hit_count_q, miss_count_q;

    logic [IDX_W-1:0]            req_idx;
    logic [ICACHE_TAG_MAX_W-1:0] req_tag;
    icache_frame_t               rd_frame;
    icache_frame_t               wr_frame;
    logic                        miss_start;
    logic                        fill;
    logic                        byte_offset_unused;

    assign req_idx            = imemaddr[IDX_W+1:2];
    assign req_tag            = ICACHE_TAG_MAX_W'(imemaddr[31:IDX_W+2]);
    assign byte_offset_unused = ^imemaddr[1:0];

    // The fill target comes from the latched miss address, not imemaddr,
    // so a dropped or redirected request still completes its own fill.
    always_comb begin
        wr_frame       = '0;
        wr_frame.valid = 1'b1;
        wr_frame.tag   = ICACHE_TAG_MAX_W'(miss_word_q[29:IDX_W]);
        wr_frame.data  = iload;
    end

    icache_frames #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_frames (
        .CLK      (CLK),
        .RST      (RST),
        .rd_idx   (req_idx),
        .rd_frame (rd_frame),
        .wr_en    (fill),
        .wr_idx   (miss_word_q[IDX_W-1:0]),
        .wr_frame (wr_frame)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        miss_start = 1'b0;
        fill       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (imemREN) begin
                    if (rd_frame.valid && (rd_frame.tag == req_tag)) begin
                        ihit     = 1'b1;
                        imemload = rd_frame.data;
                    end else begin
                        miss_start = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_word_q, 2'b00};
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_word_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (miss_start) begin
                miss_word_q  <= imemaddr[31:2];
                miss_count_q <= miss_count_q + 32'd1;
            end
            if (ihit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - self-checking bench for icache
module tb_icache;

    localparam int SETS = 16;

    logic        CLK;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    icache #(.SETS(SETS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests    = 0;
    int failures = 0;

    // Reference model: each set remembers which word address it holds.
    bit          mvalid [SETS];
    logic [29:0] mword  [SETS];
    logic [31:0] mdata  [SETS];
    logic [31:0] mhits;
    logic [31:0] mmisses;

    typedef struct {
        logic [31:0] addr;
        int          nwait;
        logic [31:0] data;
        logic        exp_hit;
        logic [31:0] exp_load;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {2'b00, a[31:2]};
        return (w * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) mvalid[s] = 1'b0;
        mhits   = 32'd0;
        mmisses = 32'd0;
    endtask

    // Starts and ends just after a rising edge. Issues one request, serves
    // any miss with nwait busy cycles, and returns the first-cycle ihit and
    // the instruction eventually delivered.
    task automatic fetch(input logic [31:0] addr, input int nwait, input logic [31:0] data,
                         output logic first_hit, output logic [31:0] got_load);
        int   i;
        logic exp_hit;
        i       = int'((addr >> 2) % SETS);
        exp_hit = mvalid[i] && (mword[i] == addr[31:2]);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        iload    = 32'hDEAD_BEEF;
        @(negedge CLK);
        first_hit = ihit;
        got_load  = imemload;
        check("req ihit", 32'(ihit), 32'(exp_hit));
        check("req iREN", 32'(iREN), 32'd0);
        if (exp_hit) begin
            check("hit imemload", imemload, mdata[i]);
            mhits++;
            @(posedge CLK);
            #1;
        end else begin
            check("miss imemload", imemload, 32'd0);
            check("miss iaddr idle", iaddr, 32'd0);
            mmisses++;
            @(posedge CLK);
            for (int c = 0; c <= nwait; c++) begin
                #1;
                iwait = (c < nwait);
                iload = (c == nwait) ? data : (32'hBAD0_0000 | 32'(c));
                @(negedge CLK);
                check("fetch iREN", 32'(iREN), 32'd1);
                check("fetch iaddr", iaddr, {addr[31:2], 2'b00});
                check("fetch ihit", 32'(ihit), 32'd0);
                @(posedge CLK);
            end
            mvalid[i] = 1'b1;
            mword[i]  = addr[31:2];
            mdata[i]  = data;
            #1;
            iwait = 1'b1;
            iload = 32'hDEAD_BEEF;
            @(negedge CLK);
            got_load = imemload;
            check("refetch ihit", 32'(ihit), 32'd1);
            check("refetch imemload", imemload, data);
            check("refetch iREN", 32'(iREN), 32'd0);
            mhits++;
            @(posedge CLK);
            #1;
        end
        check("hit_count", hit_count, mhits);
        check("miss_count", miss_count, mmisses);
    endtask

    task automatic idle_cycle(input logic [31:0] addr);
        imemREN  = 1'b0;
        imemaddr = addr;
        iwait    = 1'b1;
        @(negedge CLK);
        check("idle ihit", 32'(ihit), 32'd0);
        check("idle imemload", imemload, 32'd0);
        check("idle iREN", 32'(iREN), 32'd0);
        check("idle iaddr", iaddr, 32'd0);
        @(posedge CLK);
        #1;
        check("idle hit_count", hit_count, mhits);
        check("idle miss_count", miss_count, mmisses);
    endtask

    initial begin
        logic        fh;
        logic [31:0] ld;
        logic [31:0] ra;

        vecs[0]  = '{32'h0000_0040, 3, 32'h8C01_0004, 1'b0, 32'h8C01_0004};
        vecs[1]  = '{32'h0000_0040, 0, 32'h0,         1'b1, 32'h8C01_0004};
        vecs[2]  = '{32'h0000_0040, 0, 32'h0,         1'b1, 32'h8C01_0004};
        vecs[3]  = '{32'h0000_0040, 0, 32'h0,         1'b1, 32'h8C01_0004};
        vecs[4]  = '{32'h0000_0040, 0, 32'h0,         1'b1, 32'h8C01_0004};
        vecs[5]  = '{32'h0000_0040, 0, 32'h0,         1'b1, 32'h8C01_0004};
        vecs[6]  = '{32'h0000_0043, 0, 32'h0,         1'b1, 32'h8C01_0004};
        vecs[7]  = '{32'h0000_0080, 0, 32'h1111_2222, 1'b0, 32'h1111_2222};
        vecs[8]  = '{32'h0000_0040, 1, 32'h8C01_0004, 1'b0, 32'h8C01_0004};
        vecs[9]  = '{32'h0000_0084, 2, 32'h3333_4444, 1'b0, 32'h3333_4444};
        vecs[10] = '{32'h0000_0084, 0, 32'h0,         1'b1, 32'h3333_4444};
        vecs[11] = '{32'h0000_0040, 0, 32'h0,         1'b1, 32'h8C01_0004};

        RST      = 1'b1;
        imemREN  = 1'b0;
        imemaddr = 32'd0;
        iwait    = 1'b1;
        iload    = 32'd0;
        model_reset();

        @(negedge CLK);
        check("reset ihit", 32'(ihit), 32'd0);
        check("reset imemload", imemload, 32'd0);
        check("reset iREN", 32'(iREN), 32'd0);
        check("reset iaddr", iaddr, 32'd0);
        check("reset hit_count", hit_count, 32'd0);
        check("reset miss_count", miss_count, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int v = 0; v < 12; v++) begin
            fetch(vecs[v].addr, vecs[v].nwait, vecs[v].data, fh, ld);
            check($sformatf("vec%0d first ihit", v), 32'(fh), 32'(vecs[v].exp_hit));
            check($sformatf("vec%0d load", v), ld, vecs[v].exp_load);
            if (v == 5) check("repeat hit_count", hit_count, 32'd6);
            if (v == 8) check("conflict miss_count", miss_count, 32'd3);
        end
        check("table hit_count", hit_count, 32'd12);
        check("table miss_count", miss_count, 32'd4);

        // Abandoned request: the fill for 0x44 completes after imemREN drops.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0044;
        iwait    = 1'b1;
        @(negedge CLK);
        check("abandon first ihit", 32'(ihit), 32'd0);
        mmisses++;
        @(posedge CLK);
        #1;
        imemREN  = 1'b0;
        imemaddr = 32'h0000_0100;
        @(negedge CLK);
        check("abandon iREN busy", 32'(iREN), 32'd1);
        check("abandon iaddr busy", iaddr, 32'h0000_0044);
        @(posedge CLK);
        #1;
        iwait = 1'b0;
        iload = 32'hCAFE_F00D;
        @(negedge CLK);
        check("abandon iREN done", 32'(iREN), 32'd1);
        check("abandon iaddr done", iaddr, 32'h0000_0044);
        @(posedge CLK);
        #1;
        iwait = 1'b1;
        iload = 32'd0;
        mvalid[1] = 1'b1;
        mword[1]  = 30'h11;
        mdata[1]  = 32'hCAFE_F00D;
        @(negedge CLK);
        check("abandon after iREN", 32'(iREN), 32'd0);
        check("abandon after ihit", 32'(ihit), 32'd0);
        @(posedge CLK);
        #1;
        check("abandon miss_count", miss_count, mmisses);
        fetch(32'h0000_0044, 0, 32'h0, fh, ld);
        check("abandon refetch hit", 32'(fh), 32'd1);
        check("abandon refetch load", ld, 32'hCAFE_F00D);

        // Reset in the middle of a fill.
        imemREN  = 1'b1;
        imemaddr = 32'h0000_0200;
        iwait    = 1'b1;
        @(negedge CLK);
        check("rstmid first ihit", 32'(ihit), 32'd0);
        @(posedge CLK);
        #1;
        @(negedge CLK);
        check("rstmid iREN before", 32'(iREN), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        check("rstmid iREN async", 32'(iREN), 32'd0);
        check("rstmid iaddr async", iaddr, 32'd0);
        check("rstmid hit_count", hit_count, 32'd0);
        check("rstmid miss_count", miss_count, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        fetch(32'h0000_0200, 1, 32'h0BAD_C0DE, fh, ld);
        check("rstmid refetch misses", 32'(fh), 32'd0);
        check("rstmid refetch load", ld, 32'h0BAD_C0DE);

        // Randomized traffic against the model.
        for (int n = 0; n < 300; n++) begin
            ra = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, SETS - 1)) << 2)
                 | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) ra[31] = 1'b1;
            if ($urandom_range(0, 4) == 0) begin
                idle_cycle(ra);
            end else begin
                fetch(ra, int'($urandom_range(0, 3)), mem_word(ra), fh, ld);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache. It sits directly downstream of the pipelined datapath's fetch stage and serves `imemREN`/`imemaddr` with `ihit`/`imemload`. Misses are filled one word at a time from the memory controller over the `iREN`/`iaddr`/`iwait`/`iload` handshake. The block also keeps hit and miss counters for performance statistics.

## Interface
- SETS, 16, number of one-word frames; power of two, 2..256
- IDX_W, $clog2(SETS), index width; tag width is 30 - IDX_W
- CLK  in  1  system clock; all state updates on the rising edge
- RST  in  1  reset, asynchronous and active-high
- imemREN  in  1  datapath fetch request
- imemaddr  in  32  fetch byte address; bits [1:0] are ignored
- ihit  out  1  `imemload` is valid this cycle
- imemload  out  32  fetched instruction; 0 when `ihit`=0
- iREN  out  1  read request to the memory controller
- iaddr  out  32  word-aligned miss address to the memory controller
- iwait  in  1  memory controller busy; a low `iwait` while `iREN`=1 completes the transfer
- iload  in  32  memory read data, valid when `iwait`=0
- hit_count  out  32  number of completed hits
- miss_count  out  32  number of misses taken

## Operation
- Address split: tag = imemaddr[31:IDX_W+2], index = imemaddr[IDX_W+1:2].
- Each frame holds: valid, tag, and a 32-bit data word.
- States are IDLE and FETCH.
- IDLE behaviour:
  - Hit condition: `imemREN` & frame[index].valid & tag match.
  - On a hit: `ihit`=1 and `imemload`=frame.data, combinationally in the same cycle; `hit_count` increments.
  - On a miss (`imemREN` & not hit): latch `{imemaddr[31:2],2'b00}` into `miss_addr`, increment `miss_count`, and go to FETCH.
  - With `imemREN`=0: no action and no count.
- FETCH behaviour:
  - `iREN`=1, `iaddr`=`miss_addr`, `ihit`=0.
  - When `iwait`=0: write frame[miss_addr index] = {valid=1, tag from miss_addr, data=iload}, then go to IDLE.
  - There is no bypass. The re-presented address hits in the next IDLE cycle.
- The fill always completes once FETCH is entered, even if `imemREN` drops or `imemaddr` changes (for example on a halt or a flush). Whichever frame was in the indexed slot is evicted unconditionally.
- Outside FETCH: `iREN`=0 and `iaddr`=0.
- Counters wrap modulo 2^32.

## Timing
- Reset values: state IDLE, every valid bit 0, `miss_addr` 0, both counters 0. Consequently `ihit`=0, `imemload`=0, `iREN`=0, `iaddr`=0.
- Hit latency is 0 cycles: `ihit` is asserted in the same cycle as the request.
- Miss latency is N+2 cycles, where N is the number of `iwait`-high cycles:
  - 1 cycle to detect the miss,
  - N+1 cycles in FETCH,
  - the hit itself on the following cycle.
- If `iwait` is already low in the first FETCH cycle, the fill happens on that edge and the hit occurs 2 cycles after the request.
- `iREN` stays high continuously from FETCH entry until the edge on which `iwait`=0 is sampled; it deasserts on that edge.
- Reset asserted mid-FETCH: `iREN` drops immediately (asynchronously), no frame is written, and the state returns to IDLE. The memory controller tolerates the abandoned request.
- A request repeated at the same address never re-misses after its fill.
- Two addresses with the same index thrash, one miss per alternation.

## Structure
- Shared cache package contains:
  - `icache_frame_t` {valid, tag, data}
  - `ICACHE_SETS` default
  - the `icache_state_t` enum {IDLE, FETCH}
- `word_t` comes from `cpu_types_pkg`.
- One sub-module, `icache_frames`:
  - frame array with asynchronous clear of valid bits
  - one combinational read port
  - one synchronous write port
- The FSM, `miss_addr` register and counters live in `icache`.

## Test plan
- Cold miss: reset, imemREN=1, imemaddr=0x40, iwait high 3 cycles, iload=0x8C010004 -> iREN=1/iaddr=0x40 for 4 cycles; next cycle ihit=1, imemload=0x8C010004; miss_count=1, hit_count=1.
- Repeated hit: after the fill above, hold 0x40 for 5 cycles -> ihit=1 every cycle, iREN=0 throughout, hit_count=6.
- Conflict eviction (SETS=16): fill 0x40, then fetch 0x80 (same index, different tag) -> miss and refill; then refetch 0x40 -> miss again; miss_count=3.
- Abandoned request: drop imemREN and change imemaddr to 0x100 while in FETCH for 0x44 -> fill still completes; a later fetch of 0x44 hits with no iREN.
- Reset mid-miss: assert RST during FETCH -> iREN=0 immediately, counters 0; a re-fetch of the same address misses.
- Byte offset ignored: after filling 0x40, fetch 0x43 -> ihit=1 with the 0x40 data.
